jtframe_frame_track: RTL
========================

// Module: jtframe_frame_track
// PURPOSE
//  Upstream of the simulation dump controller: derives frame_cnt, a dump-window enable and a stalled-video
//  watchdog from the game's vertical/horizontal sync. Sits in the test harness between UUT video outputs
//  and the dump/log logic, replacing ad-hoc frame counting. Synthesisable; sim-only logging is optional.
// PARAMETERS
//  CNTW      32       width of frame_cnt
//  LINEW     12       width of line counters
//  TOUT      2000000  clk cycles without a frame before vs_tout sets
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      synchronous reset, active low
//  vs          in   1      vertical sync from UUT, active low, may be async to clk
//  hs          in   1      horizontal sync from UUT, active low, may be async to clk
//  dwnld       in   1      ROM download in progress (LED signal)
//  dump_start  in   CNTW   first frame of dump window
//  dump_len    in   CNTW   frames in dump window, 0 = unlimited
//  frame_cnt   out  CNTW   completed frames since last download end
//  frame_pls   out  1      one-cycle pulse per vs falling edge
//  line_cnt    out  LINEW  hs falling edges in current frame
//  last_lines  out  LINEW  line_cnt latched at the last frame_pls
//  dump_win    out  1      high while dumping is requested
//  vs_tout     out  1      sticky flag: no frame for TOUT cycles
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): all outputs 0, FSM IDLE, synchronisers and counters cleared.
//  - vs and hs pass through 2-flop synchronisers, then a 3rd flop for edge detection. frame_pls is
//    high exactly one cycle, 3 clk after the vs falling edge is sampled. Line edges use the same latency.
//  - frame_cnt is held at 0 while dwnld=1 and is cleared on the dwnld falling edge.
//    Otherwise it increments on frame_pls and wraps from all-ones to 0 without error.
//  - line_cnt increments on each hs edge and saturates at all-ones.
//    On frame_pls, last_lines<=line_cnt and line_cnt<=0.
//    When an hs edge and frame_pls coincide, line_cnt<=1.
//  - Dump FSM (dump_win=1 only in DUMP):
//    IDLE  -> ARMED when dwnld=0.
//    ARMED -> DUMP on the frame_pls where the incremented frame_cnt equals dump_start. dump_start=0 enters
//             DUMP on the first clk after arming. The remaining-frames counter is loaded with dump_len.
//    DUMP  -> DONE when the remaining count reaches 0 on a frame_pls (only if dump_len!=0). dump_win drops
//             the same cycle frame_cnt shows the frame dump_start+dump_len.
//    DONE  is sticky.
//    Any state -> IDLE on dwnld=1, which has priority over every other transition.
//  - Watchdog: a cycle counter is cleared on frame_pls and on dwnld=1, and saturates. vs_tout sets
//    when the counter reaches TOUT. It stays set until the next frame_pls clears it in that same cycle.
//  - Reset mid-operation: synchronous return to reset state; no partial frame is counted.
// CONFIGURATION
//  FRAME_TRACK_LOG_EN defined: on each frame_pls, $display "frame %0d lines %0d" (new frame_cnt, last_lines).
//    On vs_tout rising, $display "VS timeout at frame %0d". On DUMP entry/exit, display the frame number.
//  Undefined: no $display code is compiled. Port list and RTL behaviour are identical either way.
// TESTING
//  1 rst_n low 5 clk with vs/hs toggling -> all outputs 0; release -> first vs fall gives frame_pls +3 clk,
//    frame_cnt=1.
//  2 dwnld=0, 10 frames of 224 hs pulses each -> frame_cnt=10, last_lines=224 after each frame_pls,
//    line_cnt=0 right after it.
//  3 dump_start=4, dump_len=3 -> dump_win rises with frame_cnt=4 and falls with frame_cnt=7.
//    dump_len=0 -> dump_win stays high through frame 100.
//  4 dwnld pulse high during DUMP at frame 6 -> dump_win=0 and frame_cnt=0 while high.
//    After the fall, FSM re-arms and dump_win rises again at frame 4.
//  5 TOUT=1000, hold vs high 1500 clk -> vs_tout=1 from cycle 1000. Next vs fall -> vs_tout=0 with frame_pls.
//  6 preload frame_cnt near wrap (CNTW=4), 17 frames -> frame_cnt wraps 15->0->1, no glitch on dump_win.

Source files
------------

// File: rtl/jtframe_frame_track.sv
// Frame/line tracker for sim harnesses: frame counter, dump-window FSM and stalled-vsync watchdog.
// Define FRAME_TRACK_LOG_EN to compile in per-frame/timeout/dump $display logging (behaviour unchanged).
module jtframe_frame_track #(
  parameter int CNTW  = 32,
  parameter int LINEW = 12,
  parameter int TOUT  = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             hs,
  input  logic             dwnld,
  input  logic [CNTW-1:0]  dump_start,
  input  logic [CNTW-1:0]  dump_len,
  output logic [CNTW-1:0]  frame_cnt,
  output logic             frame_pls,
  output logic [LINEW-1:0] line_cnt,
  output logic [LINEW-1:0] last_lines,
  output logic             dump_win,
  output logic             vs_tout
);

  localparam int WDW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {IDLE, ARMED, DUMP, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNTW-1:0]  remain_reg, remain_next;
  logic [CNTW-1:0]  frame_cnt_reg, frame_inc;
  logic [LINEW-1:0] line_cnt_reg, last_lines_reg;
  logic [WDW-1:0]   wd_cnt_reg;
  logic             frame_pls_reg, vs_tout_reg, dwnld_reg;
  logic [1:0]       sync_in, sync_fall;
  logic [2:0]       sync_reg [2];

  assign sync_in = {hs, vs};

  // Two synchroniser flops plus one history flop per sync; index 0 is vs, 1 is hs.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!rst_n) sync_reg[gi] <= 3'b000;
        else        sync_reg[gi] <= {sync_reg[gi][1:0], sync_in[gi]};
      end
      assign sync_fall[gi] = sync_reg[gi][2] & ~sync_reg[gi][1];
    end
  endgenerate

  logic frame_evt, line_evt;
  assign frame_evt = sync_fall[0];
  assign line_evt  = sync_fall[1];
  assign frame_inc = frame_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwnld_reg      <= 1'b0;
      frame_pls_reg  <= 1'b0;
      frame_cnt_reg  <= '0;
      line_cnt_reg   <= '0;
      last_lines_reg <= '0;
      wd_cnt_reg     <= '0;
      vs_tout_reg    <= 1'b0;
      state_reg      <= IDLE;
      remain_reg     <= '0;
    end else begin
      dwnld_reg     <= dwnld;
      frame_pls_reg <= frame_evt;
      state_reg     <= state_next;
      remain_reg    <= remain_next;

      if (dwnld || dwnld_reg) frame_cnt_reg <= '0;
      else if (frame_evt)     frame_cnt_reg <= frame_inc;

      // A line edge landing on the frame edge is the first line of the new frame.
      if (frame_evt) begin
        last_lines_reg <= line_cnt_reg;
        line_cnt_reg   <= {{(LINEW-1){1'b0}}, line_evt};
      end else if (line_evt && line_cnt_reg != {LINEW{1'b1}}) begin
        line_cnt_reg <= line_cnt_reg + 1'b1;
      end

      if (frame_evt || dwnld) begin
        wd_cnt_reg <= '0;
      end else if (wd_cnt_reg != WDW'(TOUT)) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end

      if (frame_evt)                              vs_tout_reg <= 1'b0;
      else if (!dwnld && wd_cnt_reg == WDW'(TOUT - 1)) vs_tout_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    case (state_reg)
      IDLE:  state_next = ARMED;
      ARMED: begin
        if (dump_start == '0 || (frame_evt && frame_inc == dump_start)) begin
          state_next  = DUMP;
          remain_next = dump_len;
        end
      end
      DUMP: begin
        // A loaded length of zero never counts down, so the window stays open.
        if (frame_evt && remain_reg != '0) begin
          remain_next = remain_reg - 1'b1;
          if (remain_reg == {{(CNTW-1){1'b0}}, 1'b1}) state_next = DONE;
        end
      end
      default: state_next = state_reg;
    endcase
    if (dwnld) state_next = IDLE;
  end

  assign frame_cnt  = frame_cnt_reg;
  assign frame_pls  = frame_pls_reg;
  assign line_cnt   = line_cnt_reg;
  assign last_lines = last_lines_reg;
  assign dump_win   = (state_reg == DUMP);
  assign vs_tout    = vs_tout_reg;

`ifdef FRAME_TRACK_LOG_EN
  logic tout_prev_reg, win_prev_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tout_prev_reg <= 1'b0;
      win_prev_reg  <= 1'b0;
    end else begin
      tout_prev_reg <= vs_tout_reg;
      win_prev_reg  <= dump_win;
      if (frame_pls_reg) $display("frame %0d lines %0d", frame_cnt_reg, last_lines_reg);
      if (vs_tout_reg && !tout_prev_reg) $display("VS timeout at frame %0d", frame_cnt_reg);
      if (dump_win && !win_prev_reg) $display("dump start at frame %0d", frame_cnt_reg);
      if (!dump_win && win_prev_reg) $display("dump end at frame %0d", frame_cnt_reg);
    end
  end
`endif

endmodule
